// File: rtl/fb_scanout.sv
// fb_scanout: 640x480@60 raster timing and framebuffer scan-out.
// Drives a linear read address to framebuffer port B and realigns its
// 1-cycle read data with hsync/vsync/de/frame_start for the TMDS encoder.
// Ports:
//   clk, rst_n   pixel clock, async active-low reset
//   en           scan enable; low holds the raster idle at (0,0)
//   addr_b       framebuffer port-B read address
//   rdata_b      port-B read data, valid one clock after addr_b
//   hsync, vsync sync outputs, polarity set by SYNC_POL
//   de, rgb      data enable and pixel data (rgb=0 when de=0)
//   frame_start  one-cycle pulse with output pixel (0,0)
module fb_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int addr_width = 19,
    parameter int data_width = 12,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic [addr_width-1:0] addr_b,
    input  logic [data_width-1:0] rdata_b,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [data_width-1:0] rgb,
    output logic                  frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic INACT = ~SYNC_POL;

    // run marks that h_cnt/v_cnt hold a live raster position; the first
    // enabled edge only sets run so that (0,0) is the first counted pixel.
    logic                  run;
    logic [HW-1:0]         h_cnt;
    logic [VW-1:0]         v_cnt;
    logic [addr_width-1:0] addr_cnt;

    logic act0;
    logic hs0;
    logic vs0;
    logic fs0;
    logic v_blank;

    logic de1, hs1, vs1, fs1;
    logic de2, hs2, vs2, fs2;

    always_comb begin
        act0    = 1'b0;
        hs0     = 1'b0;
        vs0     = 1'b0;
        fs0     = 1'b0;
        v_blank = (v_cnt >= V_ACT);
        if (run) begin
            act0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);
            hs0  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
            vs0  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
            fs0  = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // Raster counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run   <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            run   <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            run <= 1'b1;
            if (run) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    if (v_cnt == V_LAST) v_cnt <= '0;
                    else                 v_cnt <= v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // Linear address: addr_cnt is the next pixel's address, addr_b the
    // registered read address presented to the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt <= '0;
            addr_b   <= '0;
        end else if (!en) begin
            addr_cnt <= '0;
            addr_b   <= '0;
        end else if (act0) begin
            addr_b   <= addr_cnt;
            addr_cnt <= addr_cnt + 1'b1;
        end else if (v_blank) begin
            addr_cnt <= '0;
            addr_b   <= '0;
        end
    end

    // Timing flags ride alongside the address and RAM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {de1, hs1, vs1, fs1} <= '0;
            {de2, hs2, vs2, fs2} <= '0;
        end else if (!en) begin
            {de1, hs1, vs1, fs1} <= '0;
            {de2, hs2, vs2, fs2} <= '0;
        end else begin
            {de1, hs1, vs1, fs1} <= {act0, hs0, vs0, fs0};
            {de2, hs2, vs2, fs2} <= {de1, hs1, vs1, fs1};
        end
    end

    // Output register, aligned with rdata_b
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= INACT;
            vsync       <= INACT;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            hsync       <= INACT;
            vsync       <= INACT;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs2 ? SYNC_POL : INACT;
            vsync       <= vs2 ? SYNC_POL : INACT;
            de          <= de2;
            rgb         <= de2 ? rdata_b : '0;
            frame_start <= fs2;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed bench for fb_scanout.
// Full-size raster for latency/line/enable/reset; a shrunken raster for frame timing.
module tb_fb_scanout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        en_s;

    logic [18:0] addr_b, addr_s;
    logic [11:0] rdata_b, rdata_s;
    logic [11:0] rgb, rgb_s;
    logic        hsync, vsync, de, frame_start;
    logic        hsync_s, vsync_s, de_s, fs_s;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    localparam logic [34:0] IDLE = {2'b11, 1'b0, 12'h000, 19'h0, 1'b0};
    logic [34:0] o_main;
    logic [34:0] o_small;
    assign o_main  = {hsync, vsync, de, rgb, addr_b, frame_start};
    assign o_small = {hsync_s, vsync_s, de_s, rgb_s, addr_s, fs_s};

    always #5 clk = ~clk;

    // RAM models: mem[k] = k[11:0], one-clock read latency
    always @(posedge clk) begin
        rdata_b <= addr_b[11:0];
        rdata_s <= addr_s[11:0];
    end

    fb_scanout u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .addr_b      (addr_b),
        .rdata_b     (rdata_b),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    // 16x8 total raster: 8x4 active, hsync h 10..12, vsync lines 5..6
    fb_scanout #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) u_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en_s),
        .addr_b      (addr_s),
        .rdata_b     (rdata_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .de          (de_s),
        .rgb         (rgb_s),
        .frame_start (fs_s)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Raise en mid-cycle; edge 0 is the first counting edge.
    task automatic start(input string tag);
        en     = 1'b1;
        edge_n = -1;
        tick();
        check({tag, "_e0"}, {de, addr_b}, 0);
        tick();
        check({tag, "_e1"}, {de, addr_b}, 0);
        tick();
        check({tag, "_e2"}, {de, addr_b}, {1'b0, 19'd1});
        tick();
        check({tag, "_e3"}, {de, rgb, frame_start, hsync},
              {1'b1, 12'h000, 1'b1, 1'b1});
    endtask

    int de_cnt, hs_cnt, bad;
    int vs_cnt, rises, fs_n, fs_first, fs_second;
    logic prev_de;

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        en_s  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_main", o_main, IDLE);
        check("rst_small", o_small, IDLE);
        #20;
        @(negedge clk) rst_n = 1'b1;
        repeat (50) begin
            tick();
            check("idle", o_main, IDLE);
        end

        // Read latency and first line
        @(negedge clk);
        start("lat");
        de_cnt = 1;
        hs_cnt = 0;
        bad    = 0;
        while (edge_n < 803) begin
            tick();
            if (edge_n <= 802) begin
                if (de) de_cnt++;
                if (!hsync) hs_cnt++;
                if (de && rgb != 12'(edge_n - 3)) bad++;
                if (!de && rgb != 12'h000) bad++;
                if (!vsync || frame_start) bad++;
            end
            case (edge_n)
                641: check("addr_last", addr_b, 639);
                642: check("last_px", {de, rgb}, {1'b1, 12'h27f});
                643: check("de_fall", {de, rgb}, 0);
                658: check("hs_pre", hsync, 1);
                659: check("hs_fall", hsync, 0);
                755: check("hs_rise", hsync, 1);
                801: check("addr_l1", addr_b, 640);
                802: check("de_gap", de, 0);
                803: check("line1", {de, rgb}, {1'b1, 12'h280});
                default: ;
            endcase
        end
        check("de_len", de_cnt, 640);
        check("hs_len", hs_cnt, 96);
        check("line0", bad, 0);

        // Drop en at h=100, v=10
        while (edge_n < 8100) tick();
        check("pre_drop", {de, rgb, vsync}, {1'b1, 12'h961, 1'b1});
        check("pre_addr", addr_b, 6499);
        en = 1'b0;
        tick();
        check("drop", o_main, IDLE);
        repeat (5) tick();
        check("drop_idle", o_main, IDLE);
        start("resume");

        // Async reset mid-frame at h=300, v=2
        while (edge_n < 1900) tick();
        check("pre_rst", {de, rgb}, {1'b1, 12'h629});
        check("pre_rst_a", addr_b, 19'h62b);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst", o_main, IDLE);
        #2;
        check("async_hold", o_main, IDLE);
        en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_idle", o_main, IDLE);
        @(negedge clk);
        start("post_rst");
        en = 1'b0;
        tick();
        check("post_rst_off", o_main, IDLE);

        // Frame timing on the small raster (frame = 128 clocks)
        @(negedge clk);
        en_s     = 1'b1;
        edge_n   = -1;
        de_cnt   = 0;
        vs_cnt   = 0;
        rises    = 0;
        fs_n     = 0;
        fs_first = -1;
        fs_second = -1;
        prev_de  = 1'b0;
        while (edge_n < 260) begin
            tick();
            if (edge_n >= 3 && edge_n <= 130) begin
                if (de_s) de_cnt++;
                if (!vsync_s) vs_cnt++;
                if (de_s && !prev_de) rises++;
            end
            prev_de = de_s;
            if (fs_s) begin
                fs_n++;
                if (fs_first < 0) fs_first = edge_n;
                else if (fs_second < 0) fs_second = edge_n;
            end
            case (edge_n)
                3:   check("s_first", {de_s, rgb_s, fs_s}, {1'b1, 12'h000, 1'b1});
                56:  check("s_addr_last", addr_s, 31);
                58:  check("s_last_px", {de_s, rgb_s}, {1'b1, 12'h01f});
                82:  check("s_vs_pre", vsync_s, 1);
                83:  check("s_vs_fall", vsync_s, 0);
                114: check("s_vs_end", vsync_s, 0);
                115: check("s_vs_rise", vsync_s, 1);
                100: check("s_addr_vbl", addr_s, 0);
                130: check("s_addr_f1", addr_s, 1);
                131: check("s_f1", {de_s, rgb_s, fs_s}, {1'b1, 12'h000, 1'b1});
                default: ;
            endcase
        end
        check("s_de_cnt", de_cnt, 32);
        check("s_lines", rises, 4);
        check("s_vs_len", vs_cnt, 32);
        check("s_fs_n", fs_n, 3);
        check("s_fs_per", fs_second - fs_first, 128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
